// File: rtl/lvds_deserializer_if.sv
// lvds_deserializer_if: serial input legs, frame pulse and received-word outputs of the LVDS receiver
interface lvds_deserializer_if #(
  parameter int PARALLEL_WIDTH = 8,
  parameter int ERR_CNT_WIDTH  = 8
);
  logic                      rx_lvds_in_p;
  logic                      rx_lvds_in_n;
  logic                      rx_frame_pulse;
  logic [PARALLEL_WIDTH-1:0] rx_parallel_word;
  logic                      rx_word_valid;
  logic                      rx_word_toggle;
  logic                      rx_busy;
  logic                      rx_frame_err;
  logic                      rx_diff_err;
  logic [ERR_CNT_WIDTH-1:0]  rx_err_count;
  modport master (
    output rx_lvds_in_p, rx_lvds_in_n, rx_frame_pulse,
    input  rx_parallel_word, rx_word_valid, rx_word_toggle, rx_busy,
           rx_frame_err, rx_diff_err, rx_err_count
  );
  modport slave (
    input  rx_lvds_in_p, rx_lvds_in_n, rx_frame_pulse,
    output rx_parallel_word, rx_word_valid, rx_word_toggle, rx_busy,
           rx_frame_err, rx_diff_err, rx_err_count
  );
endinterface

// File: rtl/lvds_deserializer.sv
// lvds_deserializer: MSB-first LVDS receiver aligned by the transmitter frame pulse.
// Define LVDS_RX_DIFF_CHECK_EN to drop frames containing any p==n bit.
module lvds_deserializer #(
  parameter int PARALLEL_WIDTH = 8,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input logic               clk_serial,
  input logic               reset_n,
  lvds_deserializer_if.slave bus
);
  localparam int W  = PARALLEL_WIDTH;
  localparam int CW = $clog2(PARALLEL_WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] shift_q, shift_d, word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic valid_q, valid_d, tog_q, tog_d, ferr_q, ferr_d, derr_q, derr_d, flag_q, flag_d;
  logic bit_in, viol, done, start;
`ifdef LVDS_RX_DIFF_CHECK_EN
  assign viol = bus.rx_lvds_in_p == bus.rx_lvds_in_n;
`else
  logic unused_n;
  assign unused_n = bus.rx_lvds_in_n;
  assign viol = 1'b0;
`endif
  // A pulse on the completing edge finishes the word and is only reported as an error.
  always_comb begin
    bit_in  = bus.rx_lvds_in_p;
    done    = state_q == SHIFT && cnt_q == '0;
    start   = bus.rx_frame_pulse && !done;
    ferr_d  = state_q == SHIFT && bus.rx_frame_pulse;
    derr_d  = done && (flag_q || viol);
    valid_d = done && !(flag_q || viol);
    state_d = start ? SHIFT : done ? IDLE : state_q;
    cnt_d   = start ? CW'(W - 2) : (state_q == SHIFT && !done) ? cnt_q - 1'b1 : cnt_q;
    shift_d = start ? {{(W-1){1'b0}}, bit_in} : state_q == SHIFT ? {shift_q[W-2:0], bit_in} : shift_q;
    flag_d  = start ? viol : flag_q || (state_q == SHIFT && viol);
    word_d  = valid_d ? {shift_q[W-2:0], bit_in} : word_q;
    tog_d   = tog_q ^ valid_d;
    err_d   = ((ferr_d || derr_d) && !(&err_q)) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk_serial or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      tog_q   <= 1'b0;
      ferr_q  <= 1'b0;
      derr_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      tog_q   <= tog_d;
      ferr_q  <= ferr_d;
      derr_q  <= derr_d;
      flag_q  <= flag_d;
    end
  end
  assign bus.rx_parallel_word = word_q;
  assign bus.rx_word_valid    = valid_q;
  assign bus.rx_word_toggle   = tog_q;
  assign bus.rx_busy          = state_q == SHIFT;
  assign bus.rx_frame_err     = ferr_q;
  assign bus.rx_diff_err      = derr_q;
  assign bus.rx_err_count     = err_q;
endmodule

// File: tb/tb_lvds_deserializer.sv
// tb_lvds_deserializer: directed and random checks against a bit-list frame model
module tb_lvds_deserializer;
  localparam int W = 8;
`ifdef LVDS_RX_DIFF_CHECK_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif
  logic clk_serial = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk_serial = ~clk_serial;
  lvds_deserializer_if #(.PARALLEL_WIDTH(W), .ERR_CNT_WIDTH(8)) bus ();
  lvds_deserializer #(.PARALLEL_WIDTH(W), .ERR_CNT_WIDTH(8)) dut (
    .clk_serial(clk_serial),
    .reset_n(reset_n),
    .bus(bus)
  );
  bit q[$];
  bit in_frame, bad, m_valid, m_tog, m_ferr, m_derr;
  logic [W-1:0] m_word;
  logic [7:0] m_cnt;
  logic [20:0] dut_vec;
  assign dut_vec = {bus.rx_parallel_word, bus.rx_word_valid, bus.rx_word_toggle, bus.rx_busy,
                    bus.rx_frame_err, bus.rx_diff_err, bus.rx_err_count};
  function automatic logic [20:0] exp_vec();
    return {m_word, m_valid, m_tog, in_frame, m_ferr, m_derr, m_cnt};
  endfunction
  function automatic void model_reset();
    q = {};
    in_frame = 0; bad = 0; m_valid = 0; m_tog = 0; m_ferr = 0; m_derr = 0;
    m_word = '0; m_cnt = '0;
  endfunction
  function automatic void model_edge(bit p, bit n, bit pulse);
    bit v;
    v = DIFF && (p == n);
    m_valid = 0; m_ferr = 0; m_derr = 0;
    if (in_frame) begin
      q.push_back(p);
      bad = bad | v;
      if (q.size() == W) begin
        m_ferr = pulse;
        if (bad) m_derr = 1;
        else begin
          m_valid = 1;
          for (int i = 0; i < W; i++) m_word[W-1-i] = q[i];
          m_tog = ~m_tog;
        end
        in_frame = 0;
      end else if (pulse) begin
        m_ferr = 1;
        q = {p};
        bad = v;
      end
    end else if (pulse) begin
      in_frame = 1;
      q = {p};
      bad = v;
    end
    if ((m_ferr || m_derr) && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endfunction
  task automatic step(input bit p, input bit n, input bit pulse);
    @(negedge clk_serial);
    bus.rx_lvds_in_p = p;
    bus.rx_lvds_in_n = n;
    bus.rx_frame_pulse = pulse;
    model_edge(p, n, pulse);
    @(posedge clk_serial);
    #1;
  endtask
  task automatic send_frame(input logic [W-1:0] w, input int bad_bit);
    bit b;
    for (int i = 0; i < W; i++) begin
      b = w[W-1-i];
      step(b, (i == bad_bit) ? b : ~b, i == 0);
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    bus.rx_lvds_in_p = 0; bus.rx_lvds_in_n = 1; bus.rx_frame_pulse = 0;
    model_reset();
    repeat (3) @(posedge clk_serial);
    #1;
    checks++;
    if (dut_vec !== 21'd0) begin
      failures++;
      $display("FAIL reset outputs got=%h exp=%h", dut_vec, 21'd0);
    end
    @(negedge clk_serial);
    reset_n = 1'b1;
  endtask
  task automatic test_single();
    logic [W-1:0] w;
    w = 8'hA5;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], ~w[W-1-i], i == 0);
      checks++;
      if (dut_vec !== exp_vec() || bus.rx_word_valid !== (i == W - 1)) begin
        failures++;
        $display("FAIL single_A5 bit%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bus.rx_parallel_word !== 8'hA5 || bus.rx_word_toggle !== 1'b1 || bus.rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL single_A5_word got=%h/%b exp=a5/1", bus.rx_parallel_word, bus.rx_word_toggle);
    end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] ws [4];
    ws[0] = 8'h3C; ws[1] = 8'hC3; ws[2] = 8'h55; ws[3] = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      send_frame(ws[k], -1);
      checks++;
      if (dut_vec !== exp_vec() || bus.rx_word_valid !== 1'b1 || bus.rx_parallel_word !== ws[k]) begin
        failures++;
        $display("FAIL back_to_back frame%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      if (k == 0) step(0, 1, 0);
    end
    checks++;
    if (bus.rx_err_count !== 8'd0) begin
      failures++;
      $display("FAIL back_to_back_errcnt got=%0d exp=0", bus.rx_err_count);
    end
  endtask
  task automatic test_early_pulse();
    logic [W-1:0] w;
    logic [7:0] c0;
    c0 = m_cnt;
    step(1, 0, 1); step(0, 1, 0); step(1, 0, 0);
    w = 8'h81;
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], ~w[W-1-i], i == 0);
      checks++;
      if (dut_vec !== exp_vec() || bus.rx_frame_err !== (i == 0) || bus.rx_err_count !== c0 + 8'd1) begin
        failures++;
        $display("FAIL early_pulse bit%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (bus.rx_word_valid !== 1'b1 || bus.rx_parallel_word !== 8'h81) begin
      failures++;
      $display("FAIL early_pulse_word got=%h exp=81", bus.rx_parallel_word);
    end
  endtask
  task automatic test_pulse_on_done();
    send_frame(8'h5C, -1);
    step(0, 1, 0);
    for (int i = 0; i < W; i++) step(i[0], ~i[0], i == 0 || i == W - 1);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_word_valid !== 1'b1 || bus.rx_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL pulse_on_done got=%h exp=%h", dut_vec, exp_vec());
    end
    step(1, 0, 0);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL pulse_on_done_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask
  task automatic test_diff();
    logic [W-1:0] prev;
    logic [7:0] c0;
    send_frame(8'h12, -1);
    prev = bus.rx_parallel_word;
    c0 = m_cnt;
    send_frame(8'hFF, 5);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_diff_err !== DIFF || bus.rx_word_valid !== !DIFF ||
        bus.rx_parallel_word !== (DIFF ? prev : 8'hFF) || bus.rx_err_count !== c0 + 8'(DIFF)) begin
      failures++;
      $display("FAIL diff_FF got=%h exp=%h", dut_vec, exp_vec());
    end
    send_frame(8'h66, -1);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_parallel_word !== 8'h66 || bus.rx_diff_err !== 1'b0) begin
      failures++;
      $display("FAIL diff_recover got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask
  task automatic test_reset_midframe();
    step(0, 1, 1); step(1, 0, 0); step(0, 1, 0); step(1, 0, 0);
    @(negedge clk_serial);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_vec !== 21'd0) begin
        failures++;
        $display("FAIL reset_midframe cyc%0d got=%h exp=0", i, dut_vec);
      end
      @(posedge clk_serial);
    end
    @(negedge clk_serial);
    reset_n = 1'b1;
    step(1, 0, 0); step(0, 1, 0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
    send_frame(8'h5A, -1);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_parallel_word !== 8'h5A || bus.rx_word_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_then_5A got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask
  task automatic test_random();
    bit p, n, pl;
    for (int i = 0; i < 600; i++) begin
      p = bit'($urandom_range(0, 1));
      n = ($urandom_range(0, 9) == 0) ? p : ~p;
      pl = ($urandom_range(0, 6) == 0);
      step(p, n, pl);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 262; i++) step(1, 0, 1);
    checks++;
    if (dut_vec !== exp_vec() || bus.rx_err_count !== 8'hFF) begin
      failures++;
      $display("FAIL saturation got=%h exp=%h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 4; i++) step(0, 1, 1);
    checks++;
    if (bus.rx_err_count !== 8'hFF || bus.rx_frame_err !== 1'b1) begin
      failures++;
      $display("FAIL saturation_hold got=%0d exp=255", bus.rx_err_count);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_early_pulse();
    test_pulse_on_done();
    test_diff();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lvds_deserializer.md
Name: lvds_deserializer

Overview:
Receive-side counterpart of the LVDS serializer. It samples the differential serial stream MSB-first in the clk_serial domain and uses the transmitter's frame-start pulse for word alignment. It rebuilds the parallel word, presents it with a one-cycle valid strobe and a toggle for system-domain handoff, and flags framing and differential-integrity errors. It sits at the RX end of the LVDS loopback link, in the same clock domain as the serializer.

Parameters:
PARALLEL_WIDTH, 8, bits per frame; legal range 2 and up.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk_serial  input  1  fast serial clock, shared with the serializer.
reset_n  input  1  asynchronous, active-low reset.
rx_lvds_in_p  input  1  serial data, true leg.
rx_lvds_in_n  input  1  serial data, complement leg.
rx_frame_pulse  input  1  one-cycle pulse, coincident with the MSB on the line.
rx_parallel_word  output  PARALLEL_WIDTH  last good received word, held.
rx_word_valid  output  1  one-cycle strobe: rx_parallel_word just updated.
rx_word_toggle  output  1  inverts on every good word; used for CDC into the system clock.
rx_busy  output  1  high while a frame is being captured.
rx_frame_err  output  1  one-cycle strobe: frame aborted by an early frame pulse.
rx_diff_err  output  1  one-cycle strobe: word dropped on a p==n violation (see optional feature).
rx_err_count  output  ERR_CNT_WIDTH  saturating count of frame and differential errors.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register 0; bit counter 0. Reset mid-frame discards the partial word with no strobes.
- Inputs are in the clk_serial domain. No input synchronizers.
- Sampling is on posedge clk_serial. Data bit = rx_lvds_in_p.
- FSM has two states:
  - IDLE: when rx_frame_pulse is sampled high (edge S0), capture the bit into the shift register LSB, load bit counter = PARALLEL_WIDTH-2, set rx_busy=1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each edge performs shift_reg <= {shift_reg[W-2:0], bit}. When the counter is 0 on that edge (edge S(W-1)), the word is complete: rx_parallel_word <= {shift_reg[W-2:0], bit}, rx_word_valid=1 for that cycle, rx_word_toggle inverts, rx_busy=0, go to IDLE. Otherwise decrement the counter.
- Latency: the valid strobe is registered at edge S(W-1), which is S7 for W=8, i.e. W-1 cycles after the frame-pulse sample.
- Back-to-back frames: a frame pulse at edge S(W) is accepted as a new frame.
- Early frame pulse (rx_frame_pulse high in SHIFT with counter != 0):
  - Discard the partial word.
  - Pulse rx_frame_err for one cycle.
  - Increment rx_err_count.
  - Restart capture with this bit as the MSB; counter reloads to W-2; stay in SHIFT.
- Frame pulse on the completing edge: complete the current word normally and do not start a new frame.
- A pulse sampled on the completing edge is treated as a line fault. It counts as a frame error and gives one rx_frame_err strobe in the same cycle as rx_word_valid.
- rx_err_count saturates at all-ones and never wraps. Simultaneous frame and differential errors increment it by 1.
- rx_parallel_word changes only on a good word.

Optional Feature:
Macro LVDS_RX_DIFF_CHECK_EN.
- Defined: every bit captured in a frame checks rx_lvds_in_p != rx_lvds_in_n; any p==n sets a sticky per-frame flag. At completion, a flagged frame is dropped: no rx_word_valid, no toggle, word unchanged, rx_diff_err=1 for one cycle, rx_err_count increments. The flag clears at each frame start.
- Undefined: rx_lvds_in_n is ignored; rx_diff_err is tied to 0.

Test Plan:
- Reset, then word 8'hA5: p stream 1,0,1,0,0,1,0,1 with frame_pulse on the first bit -> rx_word_valid at S7, rx_parallel_word=8'hA5, toggle 0->1, error strobes 0.
- Back-to-back frames 8'h3C then 8'hC3 separated by one idle cycle -> two valid strobes, words 3C then C3, toggle returns to 0, rx_err_count=0.
- Frame pulse re-asserted at bit 3 of a frame, followed by a full 8'h81 -> one rx_frame_err, rx_err_count=1, single valid with 8'h81.
- LVDS_RX_DIFF_CHECK_EN defined, n forced equal to p on bit 5 of 8'hFF -> rx_diff_err at S7, no valid, word still the previous value, rx_err_count+1. Same stimulus with the macro undefined -> valid with 8'hFF.
- reset_n asserted at bit 4 of a frame, released, then 8'h5A sent -> no strobes during or after reset, then valid with 8'h5A.
- 260 aborted frames -> rx_err_count saturates at 8'hFF.
